hash_wfsm: RTL

HASH_WFSM -- requirements
Module: hash_wfsm

---
 rtl/hash_wfsm_pkg.sv | 18 +
 rtl/hash_wfsm_if.sv | 27 ++
 rtl/hash_wfsm.sv | 103 ++++++++++
 3 files changed

// File: rtl/hash_wfsm_pkg.sv
// Shared types and sizes for the hash write-out FSM.
package hash_wfsm_pkg;

    localparam int unsigned HASH_W    = 512;
    localparam int unsigned BEAT_W    = 128;
    localparam int unsigned NUM_BEATS = 4;
    localparam int unsigned IDX_W     = 32;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWaitHash   = 3'd1,
        StIssue      = 3'd2,
        StWaitActive = 3'd3,
        StWaitDone   = 3'd4,
        StDone       = 3'd5
    } state_e;

endpackage

// File: rtl/hash_wfsm_if.sv
// Job control, digest input and single-beat write handshake between hash_wfsm and its peers.
interface hash_wfsm_if;
    import hash_wfsm_pkg::*;

    logic              start;
    logic              hash_valid;
    logic [HASH_W-1:0] hash_in;
    logic              init_master_txn;
    logic [IDX_W-1:0]  write_addr_index;
    logic [BEAT_W-1:0] wdata;
    logic              wdata_valid;
    logic              write_active;
    logic              write_done;
    logic              done;
    logic [31:0]       debug;

    modport master (
        output start, hash_valid, hash_in, write_active, write_done,
        input  init_master_txn, write_addr_index, wdata, wdata_valid, done, debug
    );

    modport slave (
        input  start, hash_valid, hash_in, write_active, write_done,
        output init_master_txn, write_addr_index, wdata, wdata_valid, done, debug
    );

endinterface

// File: rtl/hash_wfsm.sv
// Captures one 512-bit digest per job and writes it out as four 128-bit single-beat bus writes.
module hash_wfsm
    import hash_wfsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    hash_wfsm_if.slave bus
);

    state_e            state_q, state_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;

    logic [HASH_W-1:0] beat_src;
    logic [1:0]        beat_sel;
    logic [BEAT_W-1:0] next_word;
    logic              completion;

    // On the capture edge hash_q is not yet loaded, so beat 0 comes straight from hash_in.
    always_comb begin
        beat_src = (state_q == StWaitHash) ? bus.hash_in : hash_q;
        beat_sel = (state_q == StWaitHash) ? 2'd0 : beat_cnt_q + 2'd1;
        unique case (beat_sel)
            2'd0:    next_word = beat_src[HASH_W-1 -: BEAT_W];
            2'd1:    next_word = beat_src[HASH_W-1-BEAT_W -: BEAT_W];
            2'd2:    next_word = beat_src[HASH_W-1-2*BEAT_W -: BEAT_W];
            default: next_word = beat_src[BEAT_W-1:0];
        endcase
    end

    assign completion = bus.write_done &&
                        ((state_q == StWaitActive) || (state_q == StWaitDone));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            hash_q     <= '0;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hash_q     <= hash_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StWaitHash;
            end
            StWaitHash: begin
                if (bus.hash_valid) begin
                    hash_d     = bus.hash_in;
                    beat_cnt_d = 2'd0;
                    idx_d      = '0;
                    wdata_d    = next_word;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = StWaitActive;
            StWaitActive, StWaitDone: begin
                if (completion) begin
                    idx_d      = idx_q + 32'd1;
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'(NUM_BEATS - 1)) begin
                        state_d = StDone;
                    end else begin
                        wdata_d = next_word;
                        state_d = StIssue;
                    end
                end else if (state_q == StWaitActive && bus.write_active) begin
                    state_d = StWaitDone;
                end
            end
            StDone: begin
                if (bus.start) state_d = StWaitHash;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.init_master_txn  = (state_q == StIssue);
        bus.wdata_valid      = (state_q == StIssue) || (state_q == StWaitActive) ||
                               (state_q == StWaitDone);
        bus.done             = (state_q == StDone);
        bus.write_addr_index = idx_q;
        bus.wdata            = wdata_q;
        bus.debug            = {24'b0, beat_cnt_q, 3'b0, state_q};
    end

endmodule
